// File: rtl/top_sum_pkg.sv
// Shared constants for the top_sum 1-bit adder and its statistics counters.
// No logic; latency and backpressure do not apply.
package top_sum_pkg;
   localparam int CNT_W_DEF = 8;
   typedef logic [CNT_W_DEF-1:0] cnt_t;
   localparam cnt_t SAT_VAL = '1;
endpackage

// File: rtl/top_sum_satcnt.sv
// Saturating up-counter with async active-high clear; at_max decodes the held count.
// Latency 1 cycle from inc to count; never stalls, increments beyond all-ones are dropped.
module top_sum_satcnt #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt,
   output logic         o_at_max
);
   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] r_cnt;
   logic         w_at_max;

   assign w_at_max = (r_cnt == MAX);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_inc && !w_at_max) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt    = r_cnt;
   assign o_at_max = w_at_max;
endmodule

// File: rtl/top_sum.sv
// 1-bit modulo-2 adder: combinational sum/carry, 1-cycle registered copies, and
// saturating activity counters built only when TOP_SUM_STATS_EN is defined; never stalls.
module top_sum
   import top_sum_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   output logic             sum,
   output logic             carry,
   output logic             sum_q,
   output logic             carry_q,
   output logic [CNT_W-1:0] sum_cnt,
   output logic [CNT_W-1:0] carry_cnt,
   output logic             cnt_sat
);
   logic w_sum;
   logic w_carry;
   logic r_sum_q;
   logic r_carry_q;

   assign w_sum   = a ^ b;
   assign w_carry = a & b;
   assign sum     = w_sum;
   assign carry   = w_carry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum_q   <= 1'b0;
         r_carry_q <= 1'b0;
      end else begin
         r_sum_q   <= w_sum;
         r_carry_q <= w_carry;
      end
   end

   assign sum_q   = r_sum_q;
   assign carry_q = r_carry_q;

`ifdef TOP_SUM_STATS_EN
   logic w_sum_at_max;
   logic w_carry_at_max;

   top_sum_satcnt #(.W(CNT_W)) u_sum_cnt (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_inc    (w_sum),
      .o_cnt    (sum_cnt),
      .o_at_max (w_sum_at_max)
   );

   top_sum_satcnt #(.W(CNT_W)) u_carry_cnt (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_inc    (w_carry),
      .o_cnt    (carry_cnt),
      .o_at_max (w_carry_at_max)
   );

   // Both flags decode flop state and counters only clear on reset, so this is
   // already a registered, sticky-until-reset signal rising with the saturating edge.
   assign cnt_sat = w_sum_at_max | w_carry_at_max;
`else
   assign sum_cnt   = '0;
   assign carry_cnt = '0;
   assign cnt_sat   = 1'b0;
`endif
endmodule

// File: tb/tb_top_sum.sv
// Randomized self-checking bench for top_sum at CNT_W=8 and CNT_W=2 driven in parallel.
// Expected values come from plain arithmetic on event counts since the last reset.
module tb_top_sum;
`ifdef TOP_SUM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       a;
   logic       b;

   logic       sum8, carry8, sum_q8, carry_q8, sat8;
   logic [7:0] sc8, cc8;
   logic       sum2, carry2, sum_q2, carry_q2, sat2;
   logic [1:0] sc2, cc2;

   int n_cmp = 0;
   int n_bad = 0;

   // model: number of sum=1 / carry=1 samples since reset, and last captured values
   int n_sum;
   int n_carry;
   int m_sum_q;
   int m_carry_q;

   always #5 clk = ~clk;

   top_sum #(.CNT_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .a(a), .b(b),
      .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8),
      .sum_cnt(sc8), .carry_cnt(cc8), .cnt_sat(sat8)
   );

   top_sum #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .a(a), .b(b),
      .sum(sum2), .carry(carry2), .sum_q(sum_q2), .carry_q(carry_q2),
      .sum_cnt(sc2), .carry_cnt(cc2), .cnt_sat(sat2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_cnt(input int n, input int w);
      int mx;
      mx = (1 << w) - 1;
      if (!STATS) return 0;
      return (n > mx) ? mx : n;
   endfunction

   function automatic int exp_sat(input int w);
      int mx;
      mx = (1 << w) - 1;
      return (STATS && (n_sum >= mx || n_carry >= mx)) ? 1 : 0;
   endfunction

   task automatic check_regs();
      chk("sum_q8",    sum_q8,   m_sum_q);
      chk("carry_q8",  carry_q8, m_carry_q);
      chk("sum_q2",    sum_q2,   m_sum_q);
      chk("carry_q2",  carry_q2, m_carry_q);
      chk("sum_cnt8",  sc8,  exp_cnt(n_sum, 8));
      chk("carry_cnt8", cc8, exp_cnt(n_carry, 8));
      chk("cnt_sat8",  sat8, exp_sat(8));
      chk("sum_cnt2",  sc2,  exp_cnt(n_sum, 2));
      chk("carry_cnt2", cc2, exp_cnt(n_carry, 2));
      chk("cnt_sat2",  sat2, exp_sat(2));
   endtask

   function automatic void model_clear();
      n_sum     = 0;
      n_carry   = 0;
      m_sum_q   = 0;
      m_carry_q = 0;
   endfunction

   // called at a negedge: drive, check comb, cross one posedge, check state, return at negedge
   task automatic step(input logic ia, input logic ib);
      int s;
      a = ia;
      b = ib;
      s = int'(ia) + int'(ib);
      #1;
      chk("sum8",   sum8,   s % 2);
      chk("carry8", carry8, s / 2);
      chk("sum2",   sum2,   s % 2);
      chk("carry2", carry2, s / 2);
      @(posedge clk);
      if (!rst) begin
         m_sum_q   = s % 2;
         m_carry_q = s / 2;
         n_sum     = n_sum + (s % 2);
         n_carry   = n_carry + (s / 2);
      end
      #1;
      check_regs();
      @(negedge clk);
   endtask

   // reset asserted between edges; state must clear before any further clock edge
   task automatic pulse_reset();
      #2;
      rst = 1'b1;
      #1;
      model_clear();
      check_regs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int sat_tab[5];
      logic [1:0] v;
      sat_tab = '{1, 2, 3, 3, 3};

      rst = 1'b1;
      a   = 1'b0;
      b   = 1'b0;
      model_clear();
      #1;
      check_regs();
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         v = 2'(i);
         step(v[1], v[0]);
      end

      rst = 1'b0;
      step(1'b1, 1'b0);
      chk("lat_sum_q_10",   sum_q8,   1);
      chk("lat_carry_q_10", carry_q8, 0);
      step(1'b1, 1'b1);
      chk("lat_sum_q_11",   sum_q8,   0);
      chk("lat_carry_q_11", carry_q8, 1);

      pulse_reset();
      repeat (5) step(1'b1, 1'b0);
      chk("pre_rst_sum_cnt8", sc8, STATS ? 5 : 0);
      chk("pre_rst_sum_q8",   sum_q8, 1);
      pulse_reset();
      chk("post_rst_sum_cnt8", sc8, 0);
      chk("post_rst_sum_q8",   sum_q8, 0);

      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         chk("sat_seq_cnt2",   sc2,  STATS ? sat_tab[i] : 0);
         chk("sat_seq_flag2",  sat2, (STATS && i >= 2) ? 1 : 0);
         chk("sat_seq_carry2", cc2,  0);
      end

      for (int i = 0; i < 4; i++) begin
         v = 2'(i);
         step(v[1], v[0]);
      end

      for (int i = 0; i < 1000; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
